// File: rtl/jtframe_palmix.sv
// Palette RAM with CPU byte access, fade scaling and blanking for the video path.
// Latency: CPU read 1 clk; video 2 pxl_cen from the sampled col_addr to RGB, sync delays matched.
// Backpressure: none; the pipeline advances on every pxl_cen and the CPU port never stalls.
module jtframe_palmix #(
  parameter int AW = 8,
  parameter int CW = 4,
  parameter int FW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic          LVBL,
  input  logic [AW-1:0] col_addr,
  input  logic          black_n,
  input  logic          pal_cs,
  input  logic          cpu_rnw,
  input  logic [AW:0]   cpu_addr,
  input  logic [7:0]    cpu_dout,
  output logic [7:0]    pal_dout,
  input  logic          fade_start,
  input  logic          fade_dir,
  input  logic [3:0]    fade_rate,
  output logic          fade_busy,
  output logic          LHBL_dly,
  output logic          LVBL_dly,
  output logic [CW-1:0] red,
  output logic [CW-1:0] green,
  output logic [CW-1:0] blue
);

  localparam int PW = CW + FW;
  localparam logic [FW-1:0] LMAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fade_st_t;

  // Two byte lanes so a CPU byte write never disturbs the other half of the word
  logic [7:0] ram_lo [0:(1<<AW)-1];
  logic [7:0] ram_hi [0:(1<<AW)-1];

  logic [AW-1:0]   cpu_idx;
  logic [3*CW-1:0] vid_word;
  logic [3*CW-1:0] a_word;
  logic            a_lhbl, a_lvbl;
  logic            blank;

  fade_st_t        fade_st;
  logic [FW-1:0]   level, level_step, target;
  logic [3:0]      frame_cnt;
  logic            fade_dir_r;
  logic            lvbl_l, lvbl_fall;

  assign cpu_idx    = cpu_addr[AW:1];
  assign blank      = !a_lhbl || !a_lvbl;
  assign lvbl_fall  = lvbl_l && !LVBL;
  assign target     = fade_dir_r ? LMAX : '0;
  assign level_step = fade_dir_r ? level + FW'(1) : level - FW'(1);

  // (c * (level+1)) >> FW; the product never exceeds CW+FW bits
  function automatic logic [CW-1:0] scale(input logic [CW-1:0] c, input logic [FW-1:0] l);
    logic [PW-1:0] p;
    p = PW'(c) * (PW'(l) + PW'(1));
    return p[FW +: CW];
  endfunction

  // CPU port: byte-lane write and registered byte readback
  always_ff @(posedge clk) begin
    if (pal_cs && !cpu_rnw) begin
      if (cpu_addr[0]) ram_hi[cpu_idx] <= cpu_dout;
      else             ram_lo[cpu_idx] <= cpu_dout;
    end
    pal_dout <= cpu_addr[0] ? ram_hi[cpu_idx] : ram_lo[cpu_idx];
  end

  // Video port: synchronous read, only the bits that carry colour are kept
  always_ff @(posedge clk) begin
    vid_word <= {ram_hi[col_addr][3*CW-9:0], ram_lo[col_addr]};
  end

  // Stage A: latch colour word (forced black when black_n=0) with its sync bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_word <= '0;
      a_lhbl <= 1'b0;
      a_lvbl <= 1'b0;
    end else if (pxl_cen) begin
      a_word <= vid_word & {3*CW{black_n}};
      a_lhbl <= LHBL;
      a_lvbl <= LVBL;
    end
  end

  // Stage B: fade scaling and blanking, sync bits delayed to match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red      <= '0;
      green    <= '0;
      blue     <= '0;
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
    end else if (pxl_cen) begin
      red      <= blank ? '0 : scale(a_word[3*CW-1:2*CW], level);
      green    <= blank ? '0 : scale(a_word[2*CW-1:CW],   level);
      blue     <= blank ? '0 : scale(a_word[CW-1:0],      level);
      LHBL_dly <= a_lhbl;
      LVBL_dly <= a_lvbl;
    end
  end

  // Fade FSM: level only moves on LVBL falling edges; a new start always wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fade_st    <= IDLE;
      fade_busy  <= 1'b0;
      frame_cnt  <= '0;
      level      <= LMAX;
      fade_dir_r <= 1'b0;
      lvbl_l     <= 1'b0;
    end else begin
      lvbl_l <= LVBL;
      if (fade_start) begin
        fade_dir_r <= fade_dir;
        frame_cnt  <= fade_rate;
        fade_st    <= RUN;
        fade_busy  <= 1'b1;
      end else begin
        case (fade_st)
          RUN: begin
            if (lvbl_fall) begin
              if (level == target) begin
                fade_st   <= DONE;
                fade_busy <= 1'b0;
              end else if (frame_cnt != '0) begin
                frame_cnt <= frame_cnt - 4'd1;
              end else begin
                frame_cnt <= fade_rate;
                level     <= level_step;
                if (level_step == target) begin
                  fade_st   <= DONE;
                  fade_busy <= 1'b0;
                end
              end
            end
          end
          DONE: begin
            fade_st   <= IDLE;
            fade_busy <= 1'b0;
          end
          default: begin
            fade_st   <= IDLE;
            fade_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtframe_palmix.sv
// Scoreboard bench for jtframe_palmix: CPU byte access, video pipeline and fades.
// Latency: pixel expectations retire one pxl_cen after the one that captured them.
// Backpressure: none; stimulus is fully bench-paced.
module tb_jtframe_palmix;
  localparam int AW = 8, CW = 4, FW = 4;

  logic          clk, rst_n, pxl_cen, LHBL, LVBL, black_n;
  logic [AW-1:0] col_addr;
  logic          pal_cs, cpu_rnw;
  logic [AW:0]   cpu_addr;
  logic [7:0]    cpu_dout, pal_dout;
  logic          fade_start, fade_dir, fade_busy, LHBL_dly, LVBL_dly;
  logic [3:0]    fade_rate;
  logic [CW-1:0] red, green, blue;

  jtframe_palmix #(.AW(AW), .CW(CW), .FW(FW)) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .col_addr(col_addr), .black_n(black_n), .pal_cs(pal_cs), .cpu_rnw(cpu_rnw),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .pal_dout(pal_dout),
    .fade_start(fade_start), .fade_dir(fade_dir), .fade_rate(fade_rate),
    .fade_busy(fade_busy), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly),
    .red(red), .green(green), .blue(blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int r; int g; int b; bit hb; bit vb; } px_t;

  px_t        pq[$];
  logic [7:0] rq[$];
  logic [7:0] m_lo [0:255];
  logic [7:0] m_hi [0:255];
  logic [7:0] fr_addr [4];
  int         m_lvl, m_cnt, m_dir;
  bit         m_busy, m_prev_vb;
  int         n_chk = 0, n_fail = 0;
  int         nf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sc(input int c, input int l);
    return ((c * (l + 1)) >> 4) & 15;
  endfunction

  task automatic model_reset();
    px_t z;
    m_lvl = 15; m_cnt = 0; m_dir = 0; m_busy = 0; m_prev_vb = 0;
    pq.delete();
    z.r = 0; z.g = 0; z.b = 0; z.hb = 0; z.vb = 0;
    pq.push_back(z);
  endtask

  // Reference fade behaviour for one clk edge
  task automatic model_edge(input bit start, input bit fall);
    int tgt;
    if (start) begin
      m_dir = fade_dir; m_cnt = fade_rate; m_busy = 1;
    end else if (m_busy && fall) begin
      tgt = m_dir ? 15 : 0;
      if (m_lvl == tgt) m_busy = 0;
      else if (m_cnt > 0) m_cnt--;
      else begin
        m_cnt = fade_rate;
        m_lvl = m_dir ? m_lvl + 1 : m_lvl - 1;
        if (m_lvl == tgt) m_busy = 0;
      end
    end
  endtask

  task automatic out_cmp();
    px_t e;
    logic [31:0] exp;
    if (pq.size() == 0) begin
      check("pipe_underrun", 1, 0);
    end else begin
      e = pq.pop_front();
      if (!e.hb || !e.vb) exp = {e.hb, e.vb, 12'h000};
      else exp = {e.hb, e.vb, 4'(sc(e.r, m_lvl)), 4'(sc(e.g, m_lvl)), 4'(sc(e.b, m_lvl))};
      check("pixel", {LHBL_dly, LVBL_dly, red, green, blue}, exp);
    end
  endtask

  // Wait to the next falling edge and retire the pixel of a pending pxl_cen
  task automatic settle();
    @(negedge clk);
    if (pxl_cen) begin
      out_cmp();
      pxl_cen = 1'b0;
    end
  endtask

  task automatic pix(input int addr, input bit blk, input bit hb, input bit vb,
                     input bit start, input bit dir, input int rate);
    px_t e;
    logic [15:0] w;
    settle();
    col_addr = addr[7:0]; black_n = blk; LHBL = hb; LVBL = vb;
    fade_start = start;
    if (start) begin
      fade_dir = dir; fade_rate = rate[3:0];
    end
    model_edge(start, m_prev_vb && !vb);
    m_prev_vb = vb;
    w = blk ? {m_hi[addr], m_lo[addr]} : 16'h0000;
    e.r = int'(w[11:8]); e.g = int'(w[7:4]); e.b = int'(w[3:0]); e.hb = hb; e.vb = vb;
    @(negedge clk);
    fade_start = 1'b0;
    check("busy", fade_busy, m_busy);
    pxl_cen = 1'b1;
    pq.push_back(e);
  endtask

  // Four active pixels, one hblank pixel, one vblank pixel (LVBL falls there)
  task automatic frame(input int st_pos, input bit dir, input int rate);
    for (int i = 0; i < 6; i++)
      pix(i < 4 ? int'(fr_addr[i]) : 32'h20, 1'b1, i < 4, i < 5, i == st_pos, dir, rate);
  endtask

  task automatic cpu_wr(input int a, input logic [7:0] d);
    settle();
    pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = a[8:0]; cpu_dout = d;
    if (a[0]) m_hi[a[8:1]] = d; else m_lo[a[8:1]] = d;
    @(negedge clk);
    pal_cs = 1'b0; cpu_rnw = 1'b1;
  endtask

  task automatic cpu_rd(input int a);
    settle();
    pal_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = a[8:0];
    rq.push_back(a[0] ? m_hi[a[8:1]] : m_lo[a[8:1]]);
    @(negedge clk);
    check("pal_dout", pal_dout, rq.pop_front());
    pal_cs = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 0; pxl_cen = 0; LHBL = 1; LVBL = 1; col_addr = 0; black_n = 1;
    pal_cs = 0; cpu_rnw = 1; cpu_addr = 0; cpu_dout = 0;
    fade_start = 0; fade_dir = 0; fade_rate = 0;
    fr_addr[0] = 8'h08; fr_addr[1] = 8'h20; fr_addr[2] = 8'h21; fr_addr[3] = 8'h30;
    model_reset();
    #3;
    check("reset_out", {red, green, blue, LHBL_dly, LVBL_dly, fade_busy}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Palette contents: 0x08=0x1234, 0x20=0x0FFF, 0x21=0x0A5C, 0x30=0xFABC
    cpu_wr(9'h010, 8'h34); cpu_wr(9'h011, 8'h12);
    cpu_wr(9'h040, 8'hFF); cpu_wr(9'h041, 8'h0F);
    cpu_wr(9'h042, 8'h5C); cpu_wr(9'h043, 8'h0A);
    cpu_wr(9'h060, 8'hBC); cpu_wr(9'h061, 8'hFA);
    cpu_rd(9'h010); cpu_rd(9'h011); cpu_rd(9'h061); cpu_rd(9'h042);

    // Plain colour, black_n, hblank and ignored upper word bits at full level
    pix(8'h08, 1, 1, 1, 0, 0, 0);
    pix(8'h08, 1, 1, 1, 0, 0, 0);
    pix(8'h08, 0, 1, 1, 0, 0, 0);
    pix(8'h21, 1, 0, 1, 0, 0, 0);
    pix(8'h30, 1, 1, 1, 0, 0, 0);
    pix(8'h21, 1, 1, 1, 0, 0, 0);
    pix(8'h20, 1, 1, 1, 0, 0, 0);

    // Fade out, two frames per step, 15 -> 0
    nf = 0;
    do begin
      frame(nf == 0 ? 0 : -1, 1'b0, 1);
      nf++;
    end while (fade_busy && nf < 40);
    check("fade_out_frames", nf, 30);
    frame(-1, 1'b0, 0);

    // Fade out requested while already at 0: done on the first frame edge
    frame(0, 1'b0, 3);
    check("at_target_busy", fade_busy, 0);

    // Fade in one step per frame to 10, then out to 7, then reverse in
    for (int i = 0; i < 10; i++) frame(i == 0 ? 0 : -1, 1'b1, 0);
    for (int i = 0; i < 3; i++) frame(i == 0 ? 0 : -1, 1'b0, 0);
    nf = 0;
    do begin
      frame(nf == 0 ? 0 : -1, 1'b1, 1);
      nf++;
    end while (fade_busy && nf < 40);
    check("fade_in_frames", nf, 16);
    frame(-1, 1'b0, 0);

    // Start coinciding with an LVBL falling edge, then run to level 5
    frame(5, 1'b0, 1);
    for (int i = 0; i < 20; i++) frame(-1, 1'b0, 1);
    check("busy_mid_fade", fade_busy, 1);

    // Asynchronous reset mid-fade
    settle();
    #2 rst_n = 0;
    #1 check("rst_mid", {red, green, blue, LHBL_dly, LVBL_dly, fade_busy}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    frame(-1, 1'b0, 0);
    frame(-1, 1'b0, 0);
    cpu_rd(9'h010); cpu_rd(9'h011); cpu_rd(9'h040); cpu_rd(9'h043);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
